ahb_port_sequencer: RTL and testbench



---
 rtl/ahb_port_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_ahb_port_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_port_sequencer.sv
// AHB-Lite slave that steps a 32-bit output port from a small FIFO of pattern words,
// releasing one word every PERIOD+1 clocks while enabled.
module ahb_port_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [31:0] oPort,
  output logic        oStrobe,
  output logic        irq
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Bus address-phase capture
  logic       addr_valid;
  logic       wr_q, rd_q;
  logic [1:0] addr_q;

  // Data-phase decode
  logic wr_data, wr_period, wr_ctrl, wr_status, flush;

  // Sequencer
  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, cnt_q, cnt_d;
  logic                en_q, en_d;
  logic                step;

  // FIFO
  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] fcnt_q, fcnt_d;
  logic            empty, full, push, pop, unf_evt, ovf_evt;

  logic [31:0] port_q;
  logic        strobe_q, unf_q, ovf_q;
  logic [31:0] status;

  logic unused_bus;
  assign unused_bus = ^{HSIZE, HADDR[31:4], HADDR[1:0]};

  assign addr_valid = HREADY & HSEL & (HTRANS != 2'b00);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= 2'd0;
    end else begin
      wr_q   <= addr_valid & HWRITE;
      rd_q   <= addr_valid & ~HWRITE;
      addr_q <= HADDR[3:2];
    end
  end

  assign wr_data   = wr_q & (addr_q == 2'd0);
  assign wr_period = wr_q & (addr_q == 2'd1);
  assign wr_ctrl   = wr_q & (addr_q == 2'd2);
  assign wr_status = wr_q & (addr_q == 2'd3);
  assign flush     = wr_ctrl & HWDATA[1];
  // The FSM reacts to the EN value being written this edge, not the stale one.
  assign en_d      = wr_ctrl ? HWDATA[0] : en_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en_d) begin
          state_d = StRun;
          cnt_d   = period_q;
        end
      end
      StRun: begin
        if (!en_d) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          step  = 1'b1;
          cnt_d = period_q;
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
    endcase
  end

  assign empty   = (fcnt_q == '0);
  assign full    = (fcnt_q == CntW'(DEPTH));
  assign pop     = step & ~flush & ~empty;
  assign unf_evt = step & ~flush & empty;
  // A pop on the same edge frees the slot a push into a full FIFO needs.
  assign push    = wr_data & (~full | pop);
  assign ovf_evt = wr_data & full & ~pop;

  always_comb begin
    fcnt_d = fcnt_q;
    if (flush) begin
      fcnt_d = '0;
    end else if (push && !pop) begin
      fcnt_d = fcnt_q + CntW'(1);
    end else if (pop && !push) begin
      fcnt_d = fcnt_q - CntW'(1);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      period_q <= '0;
      fcnt_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      port_q   <= '0;
      strobe_q <= 1'b0;
      unf_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      fcnt_q   <= fcnt_d;
      strobe_q <= pop;
      if (wr_period) begin
        period_q <= HWDATA[PERIOD_W-1:0];
      end
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PtrW'(1);
        if (pop)  rptr_q <= rptr_q + PtrW'(1);
      end
      if (pop) begin
        port_q <= mem_q[rptr_q];
      end
      // A new event on the clearing edge wins over the clear.
      unf_q <= (unf_q & ~wr_status) | unf_evt;
      ovf_q <= (ovf_q & ~wr_status) | ovf_evt;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem_q[wptr_q] <= HWDATA;
    end
  end

  assign status = {22'd0, ovf_q, unf_q, 4'(fcnt_q), 2'b00, full, empty};

  always_comb begin
    HRDATA = '0;
    if (rd_q) begin
      unique case (addr_q)
        2'd0: HRDATA = port_q;
        2'd1: HRDATA = 32'(period_q);
        2'd2: HRDATA = {31'd0, en_q};
        2'd3: HRDATA = status;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign oPort     = port_q;
  assign oStrobe   = strobe_q;
  assign irq       = unf_q;

endmodule

// File: tb/tb_ahb_port_sequencer.sv
// Bench for ahb_port_sequencer: a bus-snooping reference model fills scoreboards for
// strobes and reads; a negedge monitor compares the DUT against them.
module tb_ahb_port_sequencer;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PERIOD_W = 16;

  logic        HCLK;
  logic        HRESET;
  logic [31:0] HADDR, HWDATA, HRDATA, oPort;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HSEL, HREADYOUT, oStrobe, irq;

  ahb_port_sequencer #(.DEPTH(DEPTH), .PERIOD_W(PERIOD_W)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HSIZE    (HSIZE),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HREADY   (HREADY),
    .HSEL     (HSEL),
    .HRDATA   (HRDATA),
    .HREADYOUT(HREADYOUT),
    .oPort    (oPort),
    .oStrobe  (oStrobe),
    .irq      (irq)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  typedef struct packed {
    int unsigned c;
    logic [31:0] v;
  } strobe_t;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  strobe_t     sq[$];
  logic [31:0] rdq[$];
  logic [15:0] m_period = '0;
  logic        m_en = 1'b0, m_run = 1'b0, m_unf = 1'b0, m_ovf = 1'b0;
  int unsigned m_next = 0;
  logic [31:0] m_oport = '0;
  logic        m_wr_ph = 1'b0, m_rd_ph = 1'b0;
  logic [1:0]  m_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] read_val(input logic [1:0] a);
    int unsigned n;
    n = mq.size();
    case (a)
      2'd0:    return m_oport;
      2'd1:    return {16'd0, m_period};
      2'd2:    return {31'd0, m_en};
      default: return {22'd0, m_ovf, m_unf, n[3:0], 2'b00, n == DEPTH, n == 0};
    endcase
  endfunction

  always @(posedge HCLK) cyc <= cyc + 1;

  // Model: applies the data phase that ends at this edge, then captures the new address phase.
  always @(posedge HCLK or posedge HRESET) begin : model
    int unsigned c;
    logic        wd, wp, wc, ws, fl, en_new, valid;
    strobe_t     s;
    if (HRESET) begin
      mq.delete();
      sq.delete();
      rdq.delete();
      m_period = '0;
      m_en     = 1'b0;
      m_run    = 1'b0;
      m_unf    = 1'b0;
      m_ovf    = 1'b0;
      m_oport  = '0;
      m_wr_ph  = 1'b0;
      m_rd_ph  = 1'b0;
    end else begin
      c      = cyc + 1;
      wd     = m_wr_ph && m_addr == 2'd0;
      wp     = m_wr_ph && m_addr == 2'd1;
      wc     = m_wr_ph && m_addr == 2'd2;
      ws     = m_wr_ph && m_addr == 2'd3;
      fl     = wc && HWDATA[1];
      en_new = wc ? HWDATA[0] : m_en;
      if (ws) begin
        m_unf = 1'b0;
        m_ovf = 1'b0;
      end
      if (m_run && !en_new) begin
        m_run = 1'b0;
      end else if (m_run && c == m_next) begin
        if (!fl) begin
          if (mq.size() > 0) begin
            m_oport = mq.pop_front();
            s.c = c;
            s.v = m_oport;
            sq.push_back(s);
          end else begin
            m_unf = 1'b1;
          end
        end
        m_next = c + 32'(m_period) + 1;
      end else if (!m_run && en_new) begin
        m_run  = 1'b1;
        m_next = c + 32'(m_period) + 1;
      end
      if (fl) mq.delete();
      if (wd) begin
        if (mq.size() < DEPTH) mq.push_back(HWDATA);
        else m_ovf = 1'b1;
      end
      if (wp) m_period = HWDATA[15:0];
      m_en    = en_new;
      valid   = HREADY && HSEL && HTRANS != 2'b00;
      m_wr_ph = valid && HWRITE;
      m_rd_ph = valid && !HWRITE;
      m_addr  = HADDR[3:2];
      if (m_rd_ph) rdq.push_back(read_val(m_addr));
    end
  end

  // Monitor
  always @(negedge HCLK) begin : monitor
    strobe_t s;
    if (!HRESET) begin
      check("oPort", oPort, m_oport);
      check("irq", 32'(irq), 32'(m_unf));
      check("HREADYOUT", 32'(HREADYOUT), 32'd1);
      if (m_rd_ph) begin
        if (rdq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read scoreboard: got %h expected none queued", HRDATA);
        end else begin
          check("HRDATA", HRDATA, rdq.pop_front());
        end
      end else begin
        check("HRDATA idle", HRDATA, 32'd0);
      end
      if (sq.size() > 0 && sq[0].c == cyc) begin
        s = sq.pop_front();
        check("oStrobe step", 32'(oStrobe), 32'd1);
        check("strobe oPort", oPort, s.v);
      end else begin
        check("oStrobe quiet", 32'(oStrobe), 32'd0);
      end
    end
  end

  task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = {28'h0, off, 2'b00};
    @(posedge HCLK); #1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_read(input logic [1:0] off);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = {28'h0, off, 2'b00};
    @(posedge HCLK); #1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    @(posedge HCLK); #1;
  endtask

  task automatic read_expect(input logic [1:0] off, input logic [31:0] exp, input string name);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = {28'h0, off, 2'b00};
    @(posedge HCLK); #1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    @(negedge HCLK);
    check(name, HRDATA, exp);
    @(posedge HCLK); #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge HCLK); #1;
    end
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) begin
      @(posedge HCLK); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int unsigned e, r, k;

  initial begin
    HRESET = 1'b1;
    HADDR  = '0;
    HWDATA = '0;
    HSIZE  = 3'b010;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HREADY = 1'b1;
    HSEL   = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;

    // Reset state
    check("reset oPort", oPort, 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    check("reset oStrobe", 32'(oStrobe), 32'd0);
    read_expect(2'd0, 32'h0, "reset DATA");
    read_expect(2'd1, 32'h0, "reset PERIOD");
    read_expect(2'd2, 32'h0, "reset CTRL");
    read_expect(2'd3, 32'h1, "reset STATUS");

    // Three words at PERIOD=3
    bus_write(2'd0, 32'h11);
    bus_write(2'd0, 32'h22);
    bus_write(2'd0, 32'h33);
    bus_write(2'd1, 32'd3);
    bus_write(2'd2, 32'h1);
    e = cyc;
    wait_cyc(e + 3);
    check("s2 before first step", oPort, 32'h0);
    wait_cyc(e + 4);
    check("s2 first word", oPort, 32'h11);
    check("s2 first strobe", 32'(oStrobe), 32'd1);
    wait_cyc(e + 5);
    check("s2 strobe one cycle", 32'(oStrobe), 32'd0);
    wait_cyc(e + 8);
    check("s2 second word", oPort, 32'h22);
    wait_cyc(e + 12);
    check("s2 third word", oPort, 32'h33);
    wait_cyc(e + 15);
    check("s2 irq before underflow", 32'(irq), 32'd0);
    wait_cyc(e + 16);
    check("s2 irq underflow", 32'(irq), 32'd1);
    check("s2 oPort holds", oPort, 32'h33);
    bus_write(2'd2, 32'h0);

    // Overflow with five pushes
    bus_write(2'd3, 32'h0);
    for (int i = 1; i <= 5; i++) bus_write(2'd0, 32'hA0 + 32'(i));
    read_expect(2'd3, 32'h242, "s3 STATUS full+overflow");
    bus_write(2'd3, 32'hFFFF_FFFF);
    read_expect(2'd3, 32'h042, "s3 STATUS sticky cleared");

    // PERIOD=0 streaming with a push landing on the final pop
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'h1);
    e = cyc;
    idle(2);
    bus_write(2'd0, 32'hB5);
    check("s4 fourth word", oPort, 32'hA4);
    idle(1);
    check("s4 pushed word", oPort, 32'hB5);
    check("s4 no underflow", 32'(irq), 32'd0);
    idle(1);
    check("s4 underflow after drain", 32'(irq), 32'd1);
    bus_write(2'd2, 32'h0);

    // Stop mid-run, then flush+enable
    bus_write(2'd3, 32'h0);
    bus_write(2'd0, 32'hC1);
    bus_write(2'd0, 32'hC2);
    bus_write(2'd0, 32'hC3);
    bus_write(2'd1, 32'd5);
    bus_write(2'd2, 32'h1);
    e = cyc;
    wait_cyc(e + 6);
    check("s5 first word", oPort, 32'hC1);
    idle(2);
    bus_write(2'd2, 32'h0);
    idle(20);
    check("s5 oPort held after stop", oPort, 32'hC1);
    check("s5 no irq after stop", 32'(irq), 32'd0);
    bus_write(2'd2, 32'h3);
    e = cyc;
    read_expect(2'd3, 32'h1, "s5 STATUS flushed");
    wait_cyc(e + 5);
    check("s5 irq before period", 32'(irq), 32'd0);
    wait_cyc(e + 6);
    check("s5 irq underflow", 32'(irq), 32'd1);
    check("s5 oPort after flush", oPort, 32'hC1);
    read_expect(2'd3, 32'h101, "s5 STATUS underflow");
    bus_write(2'd2, 32'h0);

    // Asynchronous reset while running with words queued
    bus_write(2'd0, 32'hD1);
    bus_write(2'd0, 32'hD2);
    bus_write(2'd0, 32'hD3);
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'h1);
    e = cyc;
    wait_cyc(e + 5);
    check("s6 first word", oPort, 32'hD1);
    #3 HRESET = 1'b1;
    #1;
    check("s6 async oPort", oPort, 32'd0);
    check("s6 async irq", 32'(irq), 32'd0);
    check("s6 async oStrobe", 32'(oStrobe), 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    read_expect(2'd3, 32'h1, "s6 STATUS after reset");
    read_expect(2'd2, 32'h0, "s6 CTRL after reset");
    read_expect(2'd1, 32'h0, "s6 PERIOD after reset");

    // Randomized traffic, checked by the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 3) begin
        bus_write(2'd0, $urandom);
      end else if (r == 4) begin
        bus_write(2'd1, 32'hABCD_0000 | 32'($urandom_range(0, 4)));
      end else if (r == 5) begin
        k = $urandom_range(0, 7);
        bus_write(2'd2, ($urandom & 32'hFFFF_FFFC) | {30'd0, k == 0, k != 1});
      end else if (r == 6) begin
        bus_write(2'd3, $urandom);
      end else if (r == 7) begin
        bus_read(2'($urandom_range(0, 3)));
      end else if (r == 8) begin
        HSEL   = 1'b1;
        HTRANS = 2'b00;
        HWRITE = 1'b1;
        HADDR  = 32'h0;
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        HTRANS = 2'b10;
        HWDATA = $urandom;
        @(posedge HCLK); #1;
        HREADY = 1'b1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        idle(1);
      end else begin
        idle($urandom_range(0, 6));
      end
    end
    bus_write(2'd2, 32'h0);
    idle(3);
    check("strobe scoreboard drained", 32'(sq.size()), 32'd0);
    check("read scoreboard drained", 32'(rdq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
